// File: rtl/lab2_proc_muldiv_unit_if.sv
// Request/result stream bundle for the iterative multiply/divide unit.
// The master side issues requests and consumes results; the slave side is the unit.
interface lab2_proc_muldiv_unit_if #(
  parameter int p_width = 32
);
  logic               istream_val;
  logic               istream_rdy;
  logic [1:0]         istream_fn;
  logic [p_width-1:0] istream_a;
  logic [p_width-1:0] istream_b;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [p_width-1:0] ostream_msg;
  logic               flush;

  modport master (
    output istream_val, istream_fn, istream_a, istream_b, ostream_rdy, flush,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_fn, istream_a, istream_b, ostream_rdy, flush,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/lab2_proc_muldiv_unit.sv
// Iterative unsigned multiply/divide: shift-add multiply with early exit and
// restoring division, one step per cycle, valid/ready streams with flush.
module lab2_proc_muldiv_unit #(
  parameter int p_width = 32
) (
  input logic                  clk,
  input logic                  reset,
  lab2_proc_muldiv_unit_if.slave io
);
  localparam int W  = p_width;
  localparam int CW = $clog2(p_width + 1);

  localparam logic [1:0] FN_MUL   = 2'd0;
  localparam logic [1:0] FN_MULHU = 2'd1;
  localparam logic [1:0] FN_DIVU  = 2'd2;
  localparam logic [1:0] FN_REMU  = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [1:0]      fn_reg;
  logic [2*W-1:0]  a_reg;
  logic [2*W-1:0]  acc_reg;
  logic [W-1:0]    b_reg;
  logic [CW-1:0]   cnt_reg;
  logic            rdy_reg;
  logic            val_reg;
  logic [W-1:0]    msg_reg;

  logic            accept;
  logic            is_div;
  logic [2*W-1:0]  mul_acc_next;
  logic [W-1:0]    mul_b_next;
  logic [W:0]      rem_shift;
  logic            div_ge;
  logic [W-1:0]    div_rem_next;
  logic [W-1:0]    div_quo_next;
  logic            calc_last;
  logic [W-1:0]    calc_result;
  logic [W-1:0]    zero_result;

  assign io.istream_rdy = rdy_reg;
  assign io.ostream_val = val_reg;
  assign io.ostream_msg = msg_reg;

  always_comb begin
    accept       = io.istream_val && rdy_reg && !io.flush;
    is_div       = fn_reg[1];

    mul_acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    mul_b_next   = b_reg >> 1;

    // Division keeps the remainder in acc_reg[W-1:0] and shifts the dividend
    // out of a_reg[W-1:0] while quotient bits shift in from the bottom.
    rem_shift    = {acc_reg[W-1:0], a_reg[W-1]};
    div_ge       = (rem_shift >= {1'b0, b_reg});
    div_rem_next = div_ge ? W'(rem_shift - {1'b0, b_reg}) : rem_shift[W-1:0];
    div_quo_next = {a_reg[W-2:0], div_ge};

    calc_last    = is_div ? (cnt_reg == CW'(W - 1)) : (mul_b_next == '0);

    case (fn_reg)
      FN_MUL:   calc_result = mul_acc_next[W-1:0];
      FN_MULHU: calc_result = mul_acc_next[2*W-1:W];
      FN_DIVU:  calc_result = div_quo_next;
      default:  calc_result = div_rem_next;
    endcase

    // b == 0 finishes without any CALC cycle; only division has a non-zero answer.
    case (io.istream_fn)
      FN_DIVU: zero_result = '1;
      FN_REMU: zero_result = io.istream_a;
      default: zero_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      fn_reg    <= FN_MUL;
      a_reg     <= '0;
      acc_reg   <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      rdy_reg   <= 1'b1;
      val_reg   <= 1'b0;
      msg_reg   <= '0;
    end else if (io.flush) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rdy_reg   <= 1'b1;
      val_reg   <= 1'b0;
      msg_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            fn_reg  <= io.istream_fn;
            a_reg   <= {{W{1'b0}}, io.istream_a};
            b_reg   <= io.istream_b;
            acc_reg <= '0;
            cnt_reg <= '0;
            rdy_reg <= 1'b0;
            if (io.istream_b == '0) begin
              state_reg <= DONE;
              val_reg   <= 1'b1;
              msg_reg   <= zero_result;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div) begin
            acc_reg <= {{W{1'b0}}, div_rem_next};
            a_reg   <= {{W{1'b0}}, div_quo_next};
          end else begin
            acc_reg <= mul_acc_next;
            a_reg   <= a_reg << 1;
            b_reg   <= mul_b_next;
          end
          if (calc_last) begin
            state_reg <= DONE;
            val_reg   <= 1'b1;
            msg_reg   <= calc_result;
          end
        end
        DONE: begin
          if (io.ostream_rdy) begin
            state_reg <= IDLE;
            rdy_reg   <= 1'b1;
            val_reg   <= 1'b0;
            msg_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          rdy_reg   <= 1'b1;
          val_reg   <= 1'b0;
          msg_reg   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lab2_proc_muldiv_unit.sv
// Bench for the multiply/divide unit: an arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_lab2_proc_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  lab2_proc_muldiv_unit_if #(.p_width(W)) io();

  lab2_proc_muldiv_unit #(.p_width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {step count, result} from plain arithmetic.
  function automatic logic [W+7:0] ref_op(input logic [1:0] fn, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    int             n;
    p = 64'(a) * 64'(b);
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    case (fn)
      2'd0:    r = p[W-1:0];
      2'd1:    r = p[2*W-1:W];
      2'd2:    begin r = (b == 0) ? '1 : a / b; n = (b == 0) ? 0 : W; end
      default: begin r = (b == 0) ? a : a % b;  n = (b == 0) ? 0 : W; end
    endcase
    return {8'(n), r};
  endfunction

  logic         m_busy = 1'b0;
  int           m_due  = 0;
  logic [W-1:0] m_msg  = '0;
  logic [W+7:0] m_res;
  logic         m_val;

  assign m_res = ref_op(io.istream_fn, io.istream_a, io.istream_b);
  assign m_val = m_busy && (cyc >= m_due);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
    end else if (io.flush) begin
      m_busy <= 1'b0;
    end else if (m_val && io.ostream_rdy) begin
      m_busy <= 1'b0;
    end else if (!m_busy && io.istream_val) begin
      m_busy <= 1'b1;
      m_msg  <= m_res[W-1:0];
      m_due  <= cyc + int'(m_res[W+7:W]) + 1;
    end
  end

  always @(negedge clk) begin
    check("istream_rdy", io.istream_rdy, !m_busy);
    check("ostream_val", io.ostream_val, m_val);
    check("ostream_msg", io.ostream_msg, m_val ? m_msg : '0);
  end

  task automatic do_op(input logic [1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lit, input int lat, input int hold);
    int k;
    io.istream_fn  = fn;
    io.istream_a   = a;
    io.istream_b   = b;
    io.istream_val = 1'b1;
    io.ostream_rdy = (hold == 0);
    @(posedge clk); #1;
    io.istream_val = 1'b0;
    k = 1;
    while (!io.ostream_val && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    $display("op fn=%0d a=0x%0h b=0x%0h -> msg=0x%0h after %0d cycles", fn, a, b, io.ostream_msg, k);
    check("latency", 64'(k), 64'(lat));
    check("result", io.ostream_msg, lit);
    for (int i = 0; i < hold; i++) begin
      check("hold_val", io.ostream_val, 1);
      check("hold_msg", io.ostream_msg, lit);
      check("hold_rdy", io.istream_rdy, 0);
      @(posedge clk); #1;
    end
    io.ostream_rdy = 1'b1;
    @(posedge clk); #1;
    check("after_val", io.ostream_val, 0);
    check("after_rdy", io.istream_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset          = 1'b1;
    io.istream_val = 1'b0;
    io.istream_fn  = 2'd0;
    io.istream_a   = '0;
    io.istream_b   = '0;
    io.ostream_rdy = 1'b1;
    io.flush       = 1'b0;
    #1;
    check("reset_rdy", io.istream_rdy, 1);
    check("reset_val", io.ostream_val, 0);
    check("reset_msg", io.ostream_msg, 0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(2'd0, 32'd6, 32'd7, 32'd42, 4, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
    do_op(2'd2, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op(2'd3, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op(2'd3, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op(2'd0, 32'd3, 32'd0, 32'd0, 1, 5);
    do_op(2'd1, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 18, 0);
    do_op(2'd0, 32'd1, 32'h8000_0000, 32'h8000_0000, 33, 0);

    // Flush during the tenth CALC cycle of a divide.
    io.istream_fn  = 2'd2;
    io.istream_a   = 32'd1000;
    io.istream_b   = 32'd3;
    io.istream_val = 1'b1;
    @(posedge clk); #1;
    io.istream_val = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    io.flush = 1'b1;
    @(posedge clk); #1;
    io.flush = 1'b0;
    $display("flush issued: istream_rdy=%0b ostream_val=%0b", io.istream_rdy, io.ostream_val);
    check("flush_rdy", io.istream_rdy, 1);
    check("flush_val", io.ostream_val, 0);
    do_op(2'd0, 32'd2, 32'd3, 32'd6, 3, 0);

    // Asynchronous reset in the middle of a divide.
    io.istream_fn  = 2'd3;
    io.istream_a   = 32'd12345;
    io.istream_b   = 32'd11;
    io.istream_val = 1'b1;
    @(posedge clk); #1;
    io.istream_val = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    $display("mid-op reset: istream_rdy=%0b ostream_val=%0b", io.istream_rdy, io.ostream_val);
    check("areset_rdy", io.istream_rdy, 1);
    check("areset_val", io.ostream_val, 0);
    check("areset_msg", io.ostream_msg, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (io.ostream_val) seen++;
    end
    check("no_stale_result", 64'(seen), 0);
    do_op(2'd2, 32'd1000, 32'd3, 32'd333, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lab2_proc_muldiv_unit.md
LAB2_PROC_MULDIV_UNIT -- requirements
Module: lab2_proc_muldiv_unit

Interface
REQ-001 SHALL have parameter p_width, default 32, meaning operand and result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port istream_val  input  1  request valid.
REQ-005 SHALL have port istream_rdy  output  1  unit can accept a request.
REQ-006 SHALL have port istream_fn  input  2  operation: 0 MUL (low half), 1 MULHU (high half, unsigned), 2 DIVU, 3 REMU.
REQ-007 SHALL have port istream_a  input  p_width  multiplicand or dividend.
REQ-008 SHALL have port istream_b  input  p_width  multiplier or divisor.
REQ-009 SHALL have port ostream_val  output  1  result valid.
REQ-010 SHALL have port ostream_rdy  input  1  consumer accepts result.
REQ-011 SHALL have port ostream_msg  output  p_width  result.
REQ-012 SHALL have port flush  input  1  squash any in-flight operation (branch redirect).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; istream_rdy = (state == IDLE); ostream_val = (state == DONE).
REQ-014 SHALL accept a request on a rising edge where istream_val && istream_rdy && !flush, capturing fn, a, b internally.
REQ-015 SHALL treat all operands as unsigned; MUL/MULHU SHALL form the full 2*p_width-bit product, returning bits [p_width-1:0] and [2*p_width-1:p_width] respectively.
REQ-016 MUL/MULHU SHALL run one shift-add step per CALC cycle (add shifted a if b LSB set, shift b right) with early exit; number of CALC cycles N = index of highest set bit of b plus 1, N = 0 when b == 0.
REQ-017 DIVU/REMU SHALL use restoring division, one quotient bit per CALC cycle, N = p_width.
REQ-018 Divide by zero SHALL take N = 0 and return quotient all-ones (DIVU) and remainder = a (REMU).
REQ-019 On acceptance, next state SHALL be CALC if N > 0, else DONE; CALC SHALL go to DONE after its N-th cycle; ostream_val SHALL first assert N+1 cycles after the accept cycle.
REQ-020 In DONE, ostream_msg SHALL hold stable until the cycle ostream_val && ostream_rdy, after which state SHALL return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-021 ostream_msg SHALL be 0 whenever ostream_val is low.
REQ-022 flush high at a rising edge SHALL force IDLE from any state, discard the operation and any undelivered result, and block acceptance on that edge; flush SHALL take priority over result handoff in DONE.
REQ-023 Step counter SHALL be ceil(log2(p_width+1)) bits and SHALL not wrap for any legal p_width.

Reset
REQ-024 reset SHALL immediately (asynchronously) force state IDLE, clear operands, accumulator and counter; istream_rdy = 1, ostream_val = 0, ostream_msg = 0 while reset is high.
REQ-025 reset asserted mid-operation SHALL abandon the operation with no result produced after reset deasserts.
REQ-026 reset SHALL take priority over flush and all handshakes.

Verification (p_width = 32)
REQ-027 MUL a=6, b=7, ostream_rdy=1 -> ostream_val 4 cycles after accept, msg 42, then istream_rdy=1.
REQ-028 MULHU a=b=0xFFFFFFFF -> msg 0xFFFFFFFE after 33 cycles; MUL, same operands -> 0x00000001.
REQ-029 DIVU 100/7 -> 14, REMU 100/7 -> 2, both 33 cycles; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, both 1 cycle.
REQ-030 MUL 3*0, ostream_rdy low 5 cycles -> ostream_val held high, msg 0 stable, istream_rdy low; result taken on first ostream_rdy-high cycle.
REQ-031 DIVU issued, flush pulsed at CALC cycle 10 -> IDLE next cycle, no ostream_val ever; new MUL 2*3 accepted next cycle -> 6.
REQ-032 reset asserted mid-CALC between clock edges -> istream_rdy=1 and ostream_val=0 before next edge; no stale result after reset release.
